// File: rtl/reg_file.sv
// Architectural state owner: 32x32 integer bank, 32x32 float bank and the PC.
// Write-back updates registers/PC; decode reads two operands via an enable/done handshake.
module reg_file #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          ZERO_X0  = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wenable,
    input  logic        fmode,
    input  logic [4:0]  wreg,
    input  logic [31:0] wdata,
    input  logic        pcenable,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    input  logic        renable,
    input  logic [4:0]  rs1,
    input  logic        rs1_f,
    input  logic [4:0]  rs2,
    input  logic        rs2_f,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic        rdone
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned IDXW  = 5;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DONE = 1'b1
    } rd_state_e;

    logic [XLEN-1:0] xreg_q [NREGS];
    logic [XLEN-1:0] freg_q [NREGS];
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rdata1_q;
    logic [XLEN-1:0] rdata2_q;
    logic            rdone_q;
    rd_state_e       rd_state_q;

    logic            wr_x0_c;
    logic            wr_int_c;
    logic            wr_flt_c;
    logic [XLEN-1:0] rdata1_d;
    logic [XLEN-1:0] rdata2_d;

    // A write to integer x0 is dropped entirely when x0 is hardwired.
    always_comb begin
        wr_x0_c  = ZERO_X0 && (wreg == IDXW'(0));
        wr_int_c = wenable && !fmode && !wr_x0_c;
        wr_flt_c = wenable && fmode;
    end

    // Operand select: hardwired zero, then same-cycle write bypass, then array.
    always_comb begin
        rdata1_d = rs1_f ? freg_q[rs1] : xreg_q[rs1];
        if (!rs1_f && ZERO_X0 && (rs1 == IDXW'(0))) begin
            rdata1_d = '0;
        end else if ((rs1_f ? wr_flt_c : wr_int_c) && (rs1 == wreg)) begin
            rdata1_d = wdata;
        end

        rdata2_d = rs2_f ? freg_q[rs2] : xreg_q[rs2];
        if (!rs2_f && ZERO_X0 && (rs2 == IDXW'(0))) begin
            rdata2_d = '0;
        end else if ((rs2_f ? wr_flt_c : wr_int_c) && (rs2 == wreg)) begin
            rdata2_d = wdata;
        end
    end

    // Register banks and PC.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                xreg_q[i] <= '0;
                freg_q[i] <= '0;
            end
            pc_q <= RESET_PC;
        end else begin
            if (wr_int_c) begin
                xreg_q[wreg] <= wdata;
            end
            if (wr_flt_c) begin
                freg_q[wreg] <= wdata;
            end
            if (pcenable) begin
                pc_q <= next_pc;
            end
        end
    end

    // Read handshake: each sampled renable yields one rdone cycle; back-to-back allowed.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_state_q <= RD_IDLE;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            rdone_q    <= 1'b0;
        end else begin
            case (rd_state_q)
                RD_IDLE, RD_DONE: begin
                    if (renable) begin
                        rdata1_q   <= rdata1_d;
                        rdata2_q   <= rdata2_d;
                        rdone_q    <= 1'b1;
                        rd_state_q <= RD_DONE;
                    end else begin
                        rdone_q    <= 1'b0;
                        rd_state_q <= RD_IDLE;
                    end
                end
                default: begin
                    rdone_q    <= 1'b0;
                    rd_state_q <= RD_IDLE;
                end
            endcase
        end
    end

    assign pc     = pc_q;
    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;
    assign rdone  = rdone_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, writes, bank isolation, x0, bypass, handshake, PC.
module tb_reg_file;

    logic        clk;
    logic        rstn;
    logic        wenable;
    logic        fmode;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        pcenable;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        renable;
    logic [4:0]  rs1;
    logic        rs1_f;
    logic [4:0]  rs2;
    logic        rs2_f;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        rdone;

    int passed;
    int total;

    reg_file #(.RESET_PC(32'h0000_0000), .ZERO_X0(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .wenable(wenable), .fmode(fmode), .wreg(wreg), .wdata(wdata),
        .pcenable(pcenable), .next_pc(next_pc), .pc(pc),
        .renable(renable), .rs1(rs1), .rs1_f(rs1_f), .rs2(rs2), .rs2_f(rs2_f),
        .rdata1(rdata1), .rdata2(rdata2), .rdone(rdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wr(input logic f, input logic [4:0] r, input logic [31:0] d);
        wenable = 1'b1; fmode = f; wreg = r; wdata = d;
    endtask

    task automatic rd(input logic [4:0] a, input logic af, input logic [4:0] b, input logic bf);
        renable = 1'b1; rs1 = a; rs1_f = af; rs2 = b; rs2_f = bf;
    endtask

    initial begin
        passed = 0; total = 0;
        rstn = 1'b0; wenable = 1'b0; fmode = 1'b0; wreg = '0; wdata = '0;
        pcenable = 1'b0; next_pc = '0; renable = 1'b0;
        rs1 = '0; rs1_f = 1'b0; rs2 = '0; rs2_f = 1'b0;

        // T1 reset
        step(); step();
        check("rst_pc", pc, 32'h0);
        check("rst_rdone", 32'(rdone), 32'h0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_rdata2", rdata2, 32'h0);
        rstn = 1'b1;
        rd(5'd5, 1'b0, 5'd5, 1'b1);
        step();
        check("t1_rdone", 32'(rdone), 32'h1);
        check("t1_x5", rdata1, 32'h0);
        check("t1_f5", rdata2, 32'h0);
        renable = 1'b0;

        // T2 write then read
        wr(1'b0, 5'd3, 32'hDEAD_BEEF);
        step();
        wenable = 1'b0;
        rd(5'd3, 1'b0, 5'd0, 1'b0);
        step();
        check("t2_rdone", 32'(rdone), 32'h1);
        check("t2_x3", rdata1, 32'hDEAD_BEEF);
        renable = 1'b0;
        step();
        check("t2_idle_rdone", 32'(rdone), 32'h0);
        check("t2_idle_hold", rdata1, 32'hDEAD_BEEF);

        // T3 bank isolation, x0 hardwired, f0 writable
        wr(1'b1, 5'd3, 32'h3F80_0000); step();
        wr(1'b0, 5'd0, 32'h0000_1234); step();
        wr(1'b1, 5'd0, 32'h0000_0007); step();
        wenable = 1'b0;
        rd(5'd3, 1'b0, 5'd3, 1'b1);
        step();
        check("t3_x3", rdata1, 32'hDEAD_BEEF);
        check("t3_f3", rdata2, 32'h3F80_0000);
        rd(5'd0, 1'b0, 5'd0, 1'b1);
        step();
        check("t3_x0", rdata1, 32'h0);
        check("t3_f0", rdata2, 32'h7);
        renable = 1'b0;

        // T4 bypass
        wr(1'b1, 5'd7, 32'hCAFE_0007); step();
        wr(1'b0, 5'd7, 32'hA5A5_A5A5);
        rd(5'd7, 1'b0, 5'd7, 1'b0);
        step();
        check("t4_byp1", rdata1, 32'hA5A5_A5A5);
        check("t4_byp2", rdata2, 32'hA5A5_A5A5);
        wr(1'b0, 5'd7, 32'h1111_2222);
        rd(5'd7, 1'b0, 5'd7, 1'b1);
        step();
        check("t4_byp_int", rdata1, 32'h1111_2222);
        check("t4_nobyp_f7", rdata2, 32'hCAFE_0007);
        wr(1'b0, 5'd0, 32'hFFFF_FFFF);
        rd(5'd0, 1'b0, 5'd7, 1'b0);
        step();
        check("t4_x0_nobyp", rdata1, 32'h0);
        check("t4_x7_old", rdata2, 32'h1111_2222);
        wenable = 1'b0; renable = 1'b0;

        // T5 back-to-back handshake
        wr(1'b0, 5'd1, 32'h0000_0011); step();
        wr(1'b0, 5'd2, 32'h0000_0022); step();
        wenable = 1'b0;
        rd(5'd1, 1'b0, 5'd0, 1'b1); step();
        check("t5_rdone_a", 32'(rdone), 32'h1);
        check("t5_x1", rdata1, 32'h11);
        rd(5'd2, 1'b0, 5'd0, 1'b1); step();
        check("t5_rdone_b", 32'(rdone), 32'h1);
        check("t5_x2", rdata1, 32'h22);
        rd(5'd3, 1'b0, 5'd0, 1'b1); step();
        check("t5_rdone_c", 32'(rdone), 32'h1);
        check("t5_x3", rdata1, 32'hDEAD_BEEF);
        renable = 1'b0; step();
        check("t5_rdone_end", 32'(rdone), 32'h0);
        check("t5_hold", rdata1, 32'hDEAD_BEEF);

        // T6 PC, combined PC/reg write, reset mid-operation
        pcenable = 1'b1; next_pc = 32'h0000_0100; step();
        pcenable = 1'b0; next_pc = 32'h0000_0BAD;
        check("t6_pc", pc, 32'h100);
        step();
        check("t6_pc_hold", pc, 32'h100);
        pcenable = 1'b1; next_pc = 32'h0000_0200;
        wr(1'b0, 5'd9, 32'h0000_0099);
        step();
        pcenable = 1'b0; wenable = 1'b0;
        check("t6_pc_both", pc, 32'h200);
        rd(5'd9, 1'b0, 5'd9, 1'b1); step();
        check("t6_x9", rdata1, 32'h99);
        check("t6_f9", rdata2, 32'h0);
        rstn = 1'b0;
        rd(5'd1, 1'b0, 5'd0, 1'b1);
        wr(1'b0, 5'd1, 32'h0000_0999);
        pcenable = 1'b1; next_pc = 32'h0000_0300;
        step();
        check("t6_rst_rdone", 32'(rdone), 32'h0);
        check("t6_rst_pc", pc, 32'h0);
        check("t6_rst_rdata1", rdata1, 32'h0);
        rstn = 1'b1; wenable = 1'b0; pcenable = 1'b0;
        rd(5'd1, 1'b0, 5'd3, 1'b1);
        step();
        check("t6_post_rdone", 32'(rdone), 32'h1);
        check("t6_post_x1", rdata1, 32'h0);
        check("t6_post_f3", rdata2, 32'h0);
        renable = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
